// File: rtl/mem_responder_pkg.sv
// mem_rsp_pkg: shared types and constants for the line-granular memory responder.
//   - bus geometry macros (address width in bits, line size in bytes)
//   - FSM state encoding shared by the responder and anything observing it
//   - READ/WRITE encoding of the hwrite strobe
//   - saturating 32-bit increment used by the transaction counters

`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif

`ifndef LINE_SIZE
`define LINE_SIZE 16
`endif

package mem_rsp_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    RD_WAIT = 3'd2,
    RD_DATA = 3'd3,
    WDATA   = 3'd4,
    WR_WAIT = 3'd5
  } mem_rsp_state_t;

  localparam logic HWRITE_READ  = 1'b0;
  localparam logic HWRITE_WRITE = 1'b1;

  localparam int ADDR_W = `ADDR_BUS_WIDTH;
  localparam int LINE_W = `LINE_SIZE * 8;
  localparam int OFF_W  = $clog2(`LINE_SIZE);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : (value + 32'd1);
  endfunction

endpackage

// File: rtl/mem_responder_line_store.sv
// mem_line_store: DEPTH x LINE_W line array.
//   clk, rst : clock, synchronous active-high clear of every line
//   we       : write enable; waddr/wdata written at the posedge
//   raddr    : combinational read address; rdata is the addressed line

module mem_line_store #(
  parameter int DEPTH  = 256,
  parameter int LINE_W = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [LINE_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [LINE_W-1:0]        rdata
);

  logic [LINE_W-1:0] mem_r [DEPTH];

  // Line storage: full clear on reset, otherwise single write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {LINE_W{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: slave end of the arbiter-to-memory bus, one line per transaction.
//   clk, rst   : clock, synchronous active-high reset
//   hreq       : transaction request, sampled only while idle
//   haddr      : byte address (address cycle); offset bits ignored
//   hwrite     : 0 = read, 1 = write (address cycle)
//   hwdata     : write line, valid the cycle after the address cycle
//   hready     : idle/ready, or read data valid on hrdata
//   hrdata     : read line, held until the next read completes
//   oob_err    : sticky flag, an out-of-range address was captured
//   rd_count   : completed reads, saturating
//   wr_count   : completed writes (in or out of range), saturating

module mem_responder
  import mem_rsp_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hreq,
  input  logic [`ADDR_BUS_WIDTH-1:0] haddr,
  input  logic                       hwrite,
  input  logic [`LINE_SIZE*8-1:0]    hwdata,
  output logic                       hready,
  output logic [`LINE_SIZE*8-1:0]    hrdata,
  output logic                       oob_err,
  output logic [31:0]                rd_count,
  output logic [31:0]                wr_count
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int HI_LSB = OFF_W + IDX_W;

  mem_rsp_state_t    state_r;
  logic [IDX_W-1:0]  addr_idx_r;
  logic              addr_ok_r;
  logic [31:0]       wait_cnt_r;
  logic              hready_r;
  logic [LINE_W-1:0] hrdata_r;
  logic              oob_err_r;
  logic [31:0]       rd_count_r;
  logic [31:0]       wr_count_r;

  logic [IDX_W-1:0]  haddr_idx_s;
  logic              haddr_ok_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic              rd_ok_s;
  logic [LINE_W-1:0] rd_line_s;
  logic [LINE_W-1:0] rd_data_s;
  logic              wr_en_s;
  logic              unused_offset_s;

  assign haddr_idx_s     = haddr[HI_LSB-1:OFF_W];
  assign haddr_ok_s      = (haddr[ADDR_W-1:HI_LSB] == {(ADDR_W-HI_LSB){1'b0}});
  assign unused_offset_s = ^haddr[OFF_W-1:0];

  // Read port address: with READ_LAT=0 the data is loaded on the address-capture
  // edge, so the live bus address must be used while in ADDR.
  always_comb begin
    rd_idx_s = addr_idx_r;
    rd_ok_s  = addr_ok_r;
    if (state_r == ADDR) begin
      rd_idx_s = haddr_idx_s;
      rd_ok_s  = haddr_ok_s;
    end else begin
      rd_idx_s = addr_idx_r;
      rd_ok_s  = addr_ok_r;
    end
  end

  assign rd_data_s = rd_ok_s ? rd_line_s : {LINE_W{1'b0}};

  // Out-of-range writes are dropped; reset also blocks a pending commit.
  assign wr_en_s = (state_r == WDATA) && addr_ok_r && !rst;

  mem_line_store #(
    .DEPTH  (DEPTH),
    .LINE_W (LINE_W)
  ) u_store (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en_s),
    .waddr (addr_idx_r),
    .wdata (hwdata),
    .raddr (rd_idx_s),
    .rdata (rd_line_s)
  );

  // Transaction FSM; hready/hrdata are set on the edge entering the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      addr_idx_r <= {IDX_W{1'b0}};
      addr_ok_r  <= 1'b1;
      wait_cnt_r <= 32'd0;
      hready_r   <= 1'b1;
      hrdata_r   <= {LINE_W{1'b0}};
      oob_err_r  <= 1'b0;
      rd_count_r <= 32'd0;
      wr_count_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (hreq) begin
            state_r  <= ADDR;
            hready_r <= 1'b0;
          end
        end
        ADDR: begin
          addr_idx_r <= haddr_idx_s;
          addr_ok_r  <= haddr_ok_s;
          if (!haddr_ok_s) begin
            oob_err_r <= 1'b1;
          end
          if (hwrite == HWRITE_WRITE) begin
            state_r  <= WDATA;
            hready_r <= 1'b0;
          end else if (READ_LAT > 0) begin
            state_r    <= RD_WAIT;
            wait_cnt_r <= 32'(READ_LAT - 1);
            hready_r   <= 1'b0;
          end else begin
            state_r  <= RD_DATA;
            hready_r <= 1'b1;
            hrdata_r <= rd_data_s;
          end
        end
        RD_WAIT: begin
          if (wait_cnt_r == 32'd0) begin
            state_r  <= RD_DATA;
            hready_r <= 1'b1;
            hrdata_r <= rd_data_s;
          end else begin
            wait_cnt_r <= wait_cnt_r - 32'd1;
          end
        end
        RD_DATA: begin
          state_r    <= IDLE;
          hready_r   <= 1'b1;
          rd_count_r <= sat_inc(rd_count_r);
        end
        WDATA: begin
          wr_count_r <= sat_inc(wr_count_r);
          if (WRITE_LAT > 0) begin
            state_r    <= WR_WAIT;
            wait_cnt_r <= 32'(WRITE_LAT - 1);
            hready_r   <= 1'b0;
          end else begin
            state_r  <= IDLE;
            hready_r <= 1'b1;
          end
        end
        WR_WAIT: begin
          if (wait_cnt_r == 32'd0) begin
            state_r  <= IDLE;
            hready_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r - 32'd1;
          end
        end
        default: begin
          $error("mem_responder: unreachable state %0d", state_r);
          state_r  <= IDLE;
          hready_r <= 1'b1;
        end
      endcase
    end
  end

  assign hready   = hready_r;
  assign hrdata   = hrdata_r;
  assign oob_err  = oob_err_r;
  assign rd_count = rd_count_r;
  assign wr_count = wr_count_r;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder.
//   dut_a : default build (READ_LAT=2, WRITE_LAT=1)
//   dut_b : zero-latency build (READ_LAT=0, WRITE_LAT=0)
// Both share clk, rst, haddr, hwrite, hwdata; each has its own hreq.

module tb_mem_responder;
  import mem_rsp_pkg::*;

  localparam int AW   = `ADDR_BUS_WIDTH;
  localparam int LW   = `LINE_SIZE * 8;
  localparam int RL_A = 2;
  localparam int WL_A = 1;

  logic          clk;
  logic          rst;
  logic          hreq_a;
  logic          hreq_b;
  logic [AW-1:0] haddr;
  logic          hwrite;
  logic [LW-1:0] hwdata;

  logic          hready_a, hready_b;
  logic [LW-1:0] hrdata_a, hrdata_b;
  logic          oob_a, oob_b;
  logic [31:0]   rdc_a, rdc_b, wrc_a, wrc_b;

  int vectors;
  int miscompares;

  mem_responder #(.DEPTH(256), .READ_LAT(RL_A), .WRITE_LAT(WL_A)) dut_a (
    .clk(clk), .rst(rst), .hreq(hreq_a), .haddr(haddr), .hwrite(hwrite),
    .hwdata(hwdata), .hready(hready_a), .hrdata(hrdata_a), .oob_err(oob_a),
    .rd_count(rdc_a), .wr_count(wrc_a)
  );

  mem_responder #(.DEPTH(256), .READ_LAT(0), .WRITE_LAT(0)) dut_b (
    .clk(clk), .rst(rst), .hreq(hreq_b), .haddr(haddr), .hwrite(hwrite),
    .hwdata(hwdata), .hready(hready_b), .hrdata(hrdata_b), .oob_err(oob_b),
    .rd_count(rdc_b), .wr_count(wrc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkl(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? hready_b : hready_a;
  endfunction

  // Read: hready low for cycles 1..1+lat, data cycle at 2+lat, then IDLE.
  task automatic do_read(input bit sel, input logic [AW-1:0] addr,
                         input logic [LW-1:0] exp, input bit keep, input string tag);
    int lat;
    lat = sel ? 0 : RL_A;
    chk1({tag, "_idle"}, rdy(sel), 1'b1);
    haddr  = addr;
    hwrite = HWRITE_READ;
    if (sel) hreq_b = 1'b1; else hreq_a = 1'b1;
    tick();
    if (!keep) begin
      hreq_a = 1'b0;
      hreq_b = 1'b0;
    end
    for (int i = 1; i <= 1 + lat; i++) begin
      chk1({tag, "_busy"}, rdy(sel), 1'b0);
      tick();
    end
    chk1({tag, "_rdy"}, rdy(sel), 1'b1);
    chkl({tag, "_data"}, sel ? hrdata_b : hrdata_a, exp);
    tick();
  endtask

  // Write: hready low for cycles 1..2+lat, hwdata driven only in cycle 2.
  task automatic do_write(input bit sel, input logic [AW-1:0] addr,
                          input logic [LW-1:0] data, input bit keep, input string tag);
    int lat;
    lat = sel ? 0 : WL_A;
    chk1({tag, "_idle"}, rdy(sel), 1'b1);
    haddr  = addr;
    hwrite = HWRITE_WRITE;
    hwdata = ~data;
    if (sel) hreq_b = 1'b1; else hreq_a = 1'b1;
    tick();
    if (!keep) begin
      hreq_a = 1'b0;
      hreq_b = 1'b0;
    end
    chk1({tag, "_addr"}, rdy(sel), 1'b0);
    tick();
    hwdata = data;
    chk1({tag, "_wdata"}, rdy(sel), 1'b0);
    tick();
    hwdata = ~data;
    for (int i = 0; i < lat; i++) begin
      chk1({tag, "_wwait"}, rdy(sel), 1'b0);
      tick();
    end
    chk1({tag, "_done"}, rdy(sel), 1'b1);
  endtask

  initial begin
    logic [LW-1:0] zero_l, pat_a5, pat_5a, pat_d1, pat_d2, pat_d3, pat_d4, pat_ff;
    vectors     = 0;
    miscompares = 0;
    zero_l = {LW{1'b0}};
    pat_a5 = {`LINE_SIZE{8'hA5}};
    pat_5a = {`LINE_SIZE{8'h5A}};
    pat_ff = {`LINE_SIZE{8'hFF}};
    pat_d1 = {(LW/32){32'h1122_3344}};
    pat_d2 = {(LW/32){32'hDEAD_BEEF}};
    pat_d3 = {(LW/32){32'h0F0F_7788}};
    pat_d4 = {(LW/32){32'hC001_D00D}};

    rst = 1'b1; hreq_a = 1'b0; hreq_b = 1'b0;
    haddr = {AW{1'b0}}; hwrite = 1'b0; hwdata = zero_l;
    tick();
    tick();
    rst = 1'b0;
    chk1("rst_hready", hready_a, 1'b1);
    chkl("rst_hrdata", hrdata_a, zero_l);
    chk1("rst_oob", oob_a, 1'b0);
    chk32("rst_rdc", rdc_a, 32'd0);
    chk32("rst_wrc", wrc_a, 32'd0);

    // Empty array read.
    do_read(1'b0, 32'h0000_0040, zero_l, 1'b0, "rd40_empty");
    chk32("rd40_rdc", rdc_a, 32'd1);
    chk32("rd40_wrc", wrc_a, 32'd0);

    // Write then read back.
    do_write(1'b0, 32'h0000_0080, pat_a5, 1'b0, "wr80");
    chk32("wr80_wrc", wrc_a, 32'd1);
    do_read(1'b0, 32'h0000_0080, pat_a5, 1'b0, "rd80");
    chk32("rd80_rdc", rdc_a, 32'd2);
    chkl("hrdata_hold", hrdata_a, pat_a5);

    // Back-to-back with hreq held high; offset bits ignored on 0x8F.
    do_write(1'b0, 32'h0000_0040, pat_d1, 1'b1, "b2b_wr40");
    do_read (1'b0, 32'h0000_0040, pat_d1, 1'b1, "b2b_rd40");
    do_read (1'b0, 32'h0000_008F, pat_a5, 1'b1, "b2b_rd8f");
    do_write(1'b0, 32'h0000_00C0, pat_d2, 1'b1, "b2b_wrc0");
    do_read (1'b0, 32'h0000_00C0, pat_d2, 1'b0, "b2b_rdc0");
    chk32("b2b_rdc", rdc_a, 32'd5);
    chk32("b2b_wrc", wrc_a, 32'd3);

    // Out-of-range: bit 12 set aliases index 8 but must not touch it.
    chk1("oob_before", oob_a, 1'b0);
    do_write(1'b0, 32'h0000_1080, pat_5a, 1'b0, "oob_wr");
    chk1("oob_set", oob_a, 1'b1);
    chk32("oob_wrc", wrc_a, 32'd4);
    do_read(1'b0, 32'h0000_1080, zero_l, 1'b0, "oob_rd");
    do_read(1'b0, 32'h0000_0080, pat_a5, 1'b0, "oob_line8");
    chk1("oob_sticky", oob_a, 1'b1);
    chk32("oob_rdc", rdc_a, 32'd7);

    // Reset during WDATA of a write to 0x100.
    chk1("rstw_idle", hready_a, 1'b1);
    haddr = 32'h0000_0100; hwrite = HWRITE_WRITE; hwdata = pat_ff; hreq_a = 1'b1;
    tick();
    hreq_a = 1'b0;
    tick();
    chk1("rstw_in_wdata", hready_a, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("rstw_hready", hready_a, 1'b1);
    chk32("rstw_wrc", wrc_a, 32'd0);
    chk32("rstw_rdc", rdc_a, 32'd0);
    chk1("rstw_oob", oob_a, 1'b0);
    chkl("rstw_hrdata", hrdata_a, zero_l);
    do_read(1'b0, 32'h0000_0100, zero_l, 1'b0, "rstw_rd100");
    do_read(1'b0, 32'h0000_0080, zero_l, 1'b0, "rstw_rd80");
    chk32("rstw_rdc2", rdc_a, 32'd2);

    // Zero-latency build.
    chk1("z_rst_hready", hready_b, 1'b1);
    chk32("z_rst_rdc", rdc_b, 32'd0);
    do_write(1'b1, 32'h0000_0020, pat_d3, 1'b0, "z_wr20");
    do_read (1'b1, 32'h0000_0020, pat_d3, 1'b0, "z_rd20");
    do_read (1'b1, 32'h0000_0030, zero_l, 1'b0, "z_rd30_empty");
    do_write(1'b1, 32'h0000_0030, pat_d4, 1'b1, "z_b2b_wr30");
    do_read (1'b1, 32'h0000_0030, pat_d4, 1'b0, "z_b2b_rd30");
    chk32("z_wrc", wrc_b, 32'd2);
    chk32("z_rdc", rdc_b, 32'd3);
    chk32("a_untouched_rdc", rdc_a, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
